// File: rtl/demux_pkg.sv
// Shared types for the demux scheduler: state encoding, channel select type, one-hot helper.
package demux_pkg;

    localparam int NCH = 8;

    typedef enum logic [1:0] {EMPTY, HOLD, STALL} sched_state_t;

    typedef logic [2:0] sel_t;

    function automatic logic [NCH-1:0] onehot8(sel_t s);
        return 8'b0000_0001 << s;
    endfunction

endpackage

// File: rtl/demux_sched_if.sv
// Producer/consumer bundle for demux_sched; slave is the scheduler side, master the environment side.
interface demux_sched_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    import demux_pkg::*;

    logic [W-1:0]     d;
    logic             d_valid;
    logic             d_ready;
    logic [NCH-1:0]   ch_en;
    logic [W-1:0]     y;
    logic [NCH-1:0]   y_valid;
    logic [NCH-1:0]   y_ready;
    sel_t             sel;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output d, d_valid, ch_en, y_ready,
        input  d_ready, y, y_valid, sel, xfer_cnt
    );

    modport slave (
        input  d, d_valid, ch_en, y_ready,
        output d_ready, y, y_valid, sel, xfer_cnt
    );

endinterface

// File: rtl/demux_sched_rr_search.sv
// Combinational round-robin priority search: first set mask bit at or after start, wrapping mod 8.
module rr_search
    import demux_pkg::*;
(
    input  sel_t           start,
    input  logic [NCH-1:0] mask,
    output logic           found,
    output sel_t           idx
);

    sel_t cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int i = 0; i < NCH; i++) begin
            cand = start + sel_t'(i);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// One-word buffered round-robin scheduler feeding 8 channels through a shared data bus.
// Optional build macro DEMUX_SKIP_BUSY_EN: hop past a busy target to the next enabled, ready channel.
module demux_sched
    import demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          n_reset,
    demux_sched_if.slave bus
);

    sched_state_t     state_q, state_d;
    logic [W-1:0]     y_q, y_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;
    logic [NCH-1:0]   y_valid_q, y_valid_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic d_ready;
    logic in_fire;
    logic out_fire;
    sel_t sel_nxt;
    sel_t search_start;
    logic search_found;
    sel_t search_idx;

    assign sel_nxt  = sel_q + 3'd1;
    assign out_fire = y_valid_q[sel_q] & bus.y_ready[sel_q];
    // Ready is held low while reset is asserted even though the reset state is EMPTY.
    assign d_ready  = n_reset & ((state_q == EMPTY) | out_fire);
    assign in_fire  = bus.d_valid & d_ready;

    // In HOLD the next target always starts after SEL: either ptr just became SEL+1 or we retarget.
    assign search_start = (state_q == HOLD) ? sel_nxt : ptr_q;

    rr_search u_search (
        .start (search_start),
        .mask  (bus.ch_en),
        .found (search_found),
        .idx   (search_idx)
    );

`ifdef DEMUX_SKIP_BUSY_EN
    logic skip_found;
    sel_t skip_idx;

    rr_search u_skip (
        .start (sel_nxt),
        .mask  (bus.ch_en & bus.y_ready),
        .found (skip_found),
        .idx   (skip_idx)
    );
`endif

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    y_d = bus.d;
                    if (search_found) begin
                        state_d = HOLD;
                        sel_d   = search_idx;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
                    ptr_d      = sel_nxt;
                    if (in_fire) begin
                        y_d = bus.d;
                        if (search_found) begin
                            sel_d = search_idx;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (!bus.ch_en[sel_q]) begin
                    if (search_found) begin
                        sel_d = search_idx;
                    end else begin
                        state_d = STALL;
                    end
                end
`ifdef DEMUX_SKIP_BUSY_EN
                else if (!bus.y_ready[sel_q] && skip_found) begin
                    sel_d = skip_idx;
                end
`endif
            end
            STALL: begin
                if (search_found) begin
                    state_d = HOLD;
                    sel_d   = search_idx;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        y_valid_d = (state_d == HOLD) ? onehot8(sel_d) : '0;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= EMPTY;
            y_q        <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            y_valid_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            y_valid_q  <= y_valid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign bus.d_ready  = d_ready;
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.sel      = sel_q;
    assign bus.xfer_cnt = xfer_cnt_q;

endmodule
